// File: rtl/myriadrf_rx_if_pkg.sv
// Shared constants, pair-state encoding and packing helper for the MyriadRF receive interface.
package myriadrf_rx_if_pkg;

  localparam int MYRIADRF_DW = 12;
  localparam int MYRIADRF_SW = 24;

  localparam logic IQSEL_I = 1'b0;
  localparam logic IQSEL_Q = 1'b1;

  typedef enum logic {
    WAIT_I = 1'b0,
    HAVE_I = 1'b1
  } pair_state_t;

  function automatic logic [MYRIADRF_SW-1:0] pack_iq(input logic [MYRIADRF_DW-1:0] i_word,
                                                     input logic [MYRIADRF_DW-1:0] q_word);
    return {i_word, q_word};
  endfunction

endpackage

// File: rtl/myriadrf_rx_fifo.sv
// Synchronous show-ahead sample FIFO; head entry is always visible on pop_data.
module myriadrf_rx_fifo #(
  parameter int DW = 24,
  parameter int AW = 2
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push,
  input  logic [DW-1:0] push_data,
  output logic          full,
  input  logic          pop,
  output logic [DW-1:0] pop_data,
  output logic          empty,
  output logic [AW:0]   count
);

  localparam int          DEPTH   = 2 ** AW;
  localparam logic [AW:0] DEPTH_C = (AW + 1)'(DEPTH);

  logic [DW-1:0] mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          wr_en;
  logic          rd_en;

  assign full  = (count == DEPTH_C);
  assign empty = (count == '0);

  // A push into a full FIFO is still taken when the head leaves in the same cycle.
  assign wr_en = push && (!full || pop);
  assign rd_en = pop && !empty;

  assign pop_data = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else begin
      if (wr_en) begin
        mem[wr_ptr] <= push_data;
        wr_ptr      <= wr_ptr + 1'b1;
      end
      if (rd_en) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      case ({wr_en, rd_en})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/myriadrf_rx_if.sv
// MyriadRF receive interface: captures interleaved I/Q words, pairs them into 24-bit samples,
// buffers them and streams them out with valid/ready, flagging misalignment and overflow.
module myriadrf_rx_if
  import myriadrf_rx_if_pkg::*;
#(
  parameter int FIFO_AW = 2,
  parameter int CNT_W   = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   en_i,
  input  logic                   clr_i,
  input  logic [MYRIADRF_DW-1:0] rxd,
  input  logic                   rxiqsel,
  output logic [MYRIADRF_SW-1:0] m_data_o,
  output logic                   m_valid_o,
  input  logic                   m_ready_i,
  output logic                   overflow_o,
  output logic [CNT_W-1:0]       ovf_cnt_o,
  output logic                   align_err_o
);

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  logic [MYRIADRF_DW-1:0] rxd_p0;
  logic                   iqsel_p0;
  logic                   en_p0;

  pair_state_t            state_p1;
  logic [MYRIADRF_DW-1:0] i_hold_p1;

  logic                   push;
  logic [MYRIADRF_SW-1:0] push_data;
  logic                   pop;
  logic                   drop;
  logic                   align_evt;
  logic                   fifo_full;
  logic                   fifo_empty;
  logic [FIFO_AW:0]       fifo_count;

  // Stage 0: pins registered with no logic in front of them
  always_ff @(posedge clk) begin
    if (rst) begin
      rxd_p0   <= '0;
      iqsel_p0 <= IQSEL_I;
      en_p0    <= 1'b0;
    end else begin
      rxd_p0   <= rxd;
      iqsel_p0 <= rxiqsel;
      en_p0    <= en_i;
    end
  end

  // Stage 1: pair the registered words; a Q completing a held I writes the FIFO this edge
  assign push      = en_p0 && (state_p1 == HAVE_I) && (iqsel_p0 == IQSEL_Q);
  assign align_evt = en_p0 && (state_p1 == HAVE_I) && (iqsel_p0 == IQSEL_I);
  assign push_data = pack_iq(i_hold_p1, rxd_p0);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_p1  <= WAIT_I;
      i_hold_p1 <= '0;
    end else if (!en_p0) begin
      state_p1  <= WAIT_I;
      i_hold_p1 <= '0;
    end else begin
      case (state_p1)
        WAIT_I: begin
          if (iqsel_p0 == IQSEL_I) begin
            i_hold_p1 <= rxd_p0;
            state_p1  <= HAVE_I;
          end
        end
        HAVE_I: begin
          if (iqsel_p0 == IQSEL_Q) begin
            state_p1 <= WAIT_I;
          end else begin
            i_hold_p1 <= rxd_p0;
          end
        end
        default: state_p1 <= WAIT_I;
      endcase
    end
  end

  assign pop       = m_ready_i && (fifo_count != '0);
  assign m_valid_o = !fifo_empty;
  assign drop      = push && fifo_full && !pop;

  myriadrf_rx_fifo #(
    .DW(MYRIADRF_SW),
    .AW(FIFO_AW)
  ) u_fifo (
    .clk      (clk),
    .rst      (rst),
    .push     (push),
    .push_data(push_data),
    .full     (fifo_full),
    .pop      (pop),
    .pop_data (m_data_o),
    .empty    (fifo_empty),
    .count    (fifo_count)
  );

  // Status: a new event in the same cycle as clr_i takes precedence over the clear
  always_ff @(posedge clk) begin
    if (rst) begin
      overflow_o  <= 1'b0;
      ovf_cnt_o   <= '0;
      align_err_o <= 1'b0;
    end else begin
      if (drop) begin
        overflow_o <= 1'b1;
      end else if (clr_i) begin
        overflow_o <= 1'b0;
      end

      if (clr_i) begin
        ovf_cnt_o <= drop ? CNT_W'(1) : '0;
      end else if (drop) begin
        ovf_cnt_o <= sat_inc(ovf_cnt_o);
      end

      if (align_evt) begin
        align_err_o <= 1'b1;
      end else if (clr_i) begin
        align_err_o <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_myriadrf_rx_if.sv
// Directed bench for myriadrf_rx_if: inputs change on the falling edge, outputs checked there too.
module tb_myriadrf_rx_if;

  logic        clk;
  logic        rst;
  logic        en_i;
  logic        clr_i;
  logic [11:0] rxd;
  logic        rxiqsel;
  logic [23:0] m_data_o;
  logic        m_valid_o;
  logic        m_ready_i;
  logic        overflow_o;
  logic [15:0] ovf_cnt_o;
  logic        align_err_o;

  int total_checks;
  int passed_checks;
  int failed_checks;

  myriadrf_rx_if #(
    .FIFO_AW(2),
    .CNT_W  (16)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .en_i       (en_i),
    .clr_i      (clr_i),
    .rxd        (rxd),
    .rxiqsel    (rxiqsel),
    .m_data_o   (m_data_o),
    .m_valid_o  (m_valid_o),
    .m_ready_i  (m_ready_i),
    .overflow_o (overflow_o),
    .ovf_cnt_o  (ovf_cnt_o),
    .align_err_o(align_err_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step(input logic iq, input logic [11:0] d, input logic en);
    @(negedge clk);
    rxiqsel = iq;
    rxd     = d;
    en_i    = en;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total_checks++;
    assert (obs === exp) passed_checks++;
    else begin
      failed_checks++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    total_checks  = 0;
    passed_checks = 0;
    failed_checks = 0;
    rst       = 1'b1;
    en_i      = 1'b0;
    clr_i     = 1'b0;
    rxd       = '0;
    rxiqsel   = 1'b0;
    m_ready_i = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    chk("rst_valid", 32'(m_valid_o), 32'h0);
    chk("rst_data", 32'(m_data_o), 32'h0);
    chk("rst_ovf", 32'(overflow_o), 32'h0);
    chk("rst_cnt", 32'(ovf_cnt_o), 32'h0);
    chk("rst_align", 32'(align_err_o), 32'h0);

    // 1: two aligned pairs, sink always ready
    m_ready_i = 1'b1;
    step(1'b0, 12'h123, 1'b1);
    step(1'b1, 12'h456, 1'b1);
    step(1'b0, 12'hABC, 1'b1);
    chk("t1_no_early_valid", 32'(m_valid_o), 32'h0);
    step(1'b1, 12'hDEF, 1'b1);
    chk("t1_valid0", 32'(m_valid_o), 32'h1);
    chk("t1_data0", 32'(m_data_o), 32'h123456);
    step(1'b0, 12'h000, 1'b0);
    chk("t1_gap", 32'(m_valid_o), 32'h0);
    step(1'b0, 12'h000, 1'b0);
    chk("t1_valid1", 32'(m_valid_o), 32'h1);
    chk("t1_data1", 32'(m_data_o), 32'hABCDEF);
    step(1'b0, 12'h000, 1'b0);
    chk("t1_drained", 32'(m_valid_o), 32'h0);
    chk("t1_align", 32'(align_err_o), 32'h0);

    // 2: stream starts on a Q word
    step(1'b1, 12'h777, 1'b1);
    step(1'b0, 12'h321, 1'b1);
    step(1'b1, 12'h654, 1'b1);
    step(1'b0, 12'h000, 1'b0);
    step(1'b0, 12'h000, 1'b0);
    chk("t2_valid", 32'(m_valid_o), 32'h1);
    chk("t2_data", 32'(m_data_o), 32'h321654);
    chk("t2_align", 32'(align_err_o), 32'h0);
    step(1'b0, 12'h000, 1'b0);
    chk("t2_drained", 32'(m_valid_o), 32'h0);

    // 3: two I words in a row
    step(1'b0, 12'h111, 1'b1);
    step(1'b0, 12'h222, 1'b1);
    step(1'b1, 12'h333, 1'b1);
    step(1'b0, 12'h000, 1'b0);
    step(1'b0, 12'h000, 1'b0);
    chk("t3_data", 32'(m_data_o), 32'h222333);
    chk("t3_align_set", 32'(align_err_o), 32'h1);
    step(1'b0, 12'h000, 1'b0);
    chk("t3_single_sample", 32'(m_valid_o), 32'h0);
    chk("t3_align_sticky", 32'(align_err_o), 32'h1);
    clr_i = 1'b1;
    step(1'b0, 12'h000, 1'b0);
    clr_i = 1'b0;
    chk("t3_align_clr", 32'(align_err_o), 32'h0);

    // 4: sink stalled, six samples offered to a four-deep FIFO
    m_ready_i = 1'b0;
    for (int k = 1; k <= 6; k++) begin
      step(1'b0, 12'h100 + 12'(k), 1'b1);
      step(1'b1, 12'h200 + 12'(k), 1'b1);
    end
    step(1'b0, 12'h000, 1'b0);
    step(1'b0, 12'h000, 1'b0);
    chk("t4_ovf", 32'(overflow_o), 32'h1);
    chk("t4_cnt", 32'(ovf_cnt_o), 32'h2);
    chk("t4_held_valid", 32'(m_valid_o), 32'h1);
    chk("t4_held_data", 32'(m_data_o), 32'h101201);
    step(1'b0, 12'h000, 1'b0);
    m_ready_i = 1'b1;
    for (int k = 1; k <= 4; k++) begin
      chk("t4_drain_valid", 32'(m_valid_o), 32'h1);
      chk("t4_drain_data", 32'(m_data_o), {8'h00, 12'h100 + 12'(k), 12'h200 + 12'(k)});
      step(1'b0, 12'h000, 1'b0);
    end
    chk("t4_empty", 32'(m_valid_o), 32'h0);
    chk("t4_cnt_hold", 32'(ovf_cnt_o), 32'h2);
    clr_i = 1'b1;
    step(1'b0, 12'h000, 1'b0);
    clr_i = 1'b0;
    chk("t4_ovf_clr", 32'(overflow_o), 32'h0);
    chk("t4_cnt_clr", 32'(ovf_cnt_o), 32'h0);

    // 5: full FIFO, one pop coincident with the push edge
    m_ready_i = 1'b0;
    for (int k = 1; k <= 4; k++) begin
      step(1'b0, 12'h300 + 12'(k), 1'b1);
      step(1'b1, 12'h400 + 12'(k), 1'b1);
    end
    step(1'b0, 12'h305, 1'b1);
    step(1'b1, 12'h405, 1'b1);
    step(1'b0, 12'h000, 1'b0);
    m_ready_i = 1'b1;
    step(1'b0, 12'h000, 1'b0);
    m_ready_i = 1'b0;
    chk("t5_no_ovf", 32'(overflow_o), 32'h0);
    chk("t5_cnt", 32'(ovf_cnt_o), 32'h0);
    chk("t5_head", 32'(m_data_o), 32'h302402);
    m_ready_i = 1'b1;
    for (int k = 2; k <= 5; k++) begin
      chk("t5_drain_data", 32'(m_data_o), {8'h00, 12'h300 + 12'(k), 12'h400 + 12'(k)});
      step(1'b0, 12'h000, 1'b0);
    end
    chk("t5_empty", 32'(m_valid_o), 32'h0);

    // 6a: capture disabled between I and Q
    step(1'b0, 12'h555, 1'b1);
    step(1'b0, 12'h000, 1'b0);
    step(1'b1, 12'h666, 1'b1);
    step(1'b0, 12'h000, 1'b0);
    step(1'b0, 12'h000, 1'b0);
    chk("t6_en_no_sample", 32'(m_valid_o), 32'h0);
    chk("t6_en_no_err", 32'(align_err_o), 32'h0);

    // 6b: reset mid-stream with a buffered sample, a flag and a held I
    m_ready_i = 1'b0;
    step(1'b0, 12'h8AA, 1'b1);
    step(1'b0, 12'h888, 1'b1);
    step(1'b1, 12'h999, 1'b1);
    step(1'b0, 12'h777, 1'b1);
    step(1'b0, 12'h000, 1'b0);
    chk("t6_pre_data", 32'(m_data_o), 32'h888999);
    chk("t6_pre_align", 32'(align_err_o), 32'h1);
    rst = 1'b1;
    step(1'b1, 12'hAAA, 1'b1);
    rst = 1'b0;
    chk("t6_rst_valid", 32'(m_valid_o), 32'h0);
    chk("t6_rst_data", 32'(m_data_o), 32'h0);
    chk("t6_rst_align", 32'(align_err_o), 32'h0);
    m_ready_i = 1'b1;
    step(1'b0, 12'h000, 1'b0);
    step(1'b0, 12'h000, 1'b0);
    chk("t6_no_partial", 32'(m_valid_o), 32'h0);
    step(1'b0, 12'hBCD, 1'b1);
    step(1'b1, 12'hEF0, 1'b1);
    step(1'b0, 12'h000, 1'b0);
    step(1'b0, 12'h000, 1'b0);
    chk("t6_post_valid", 32'(m_valid_o), 32'h1);
    chk("t6_post_data", 32'(m_data_o), 32'hBCDEF0);
    step(1'b0, 12'h000, 1'b0);
    chk("t6_post_empty", 32'(m_valid_o), 32'h0);

    $display("%0d/%0d checks passed", passed_checks, total_checks);
    $finish;
  end

endmodule
